axi4_lite_master_tgen: RTL
==========================

# axi4_lite_master_tgen

Parametrised AXI4-Lite master traffic generator and self-checker, the next generation of the single-mode example master used in the IP's BFM bench. A rising edge on INIT_AXI_TXN runs a batch of C_M_TRANSACTIONS_NUM single-beat transfers in one of three modes: write-then-read-compare, write-only or read-compare-only. Each transfer targets an incrementing address and carries an incrementing data pattern. The block sits at the M00_AXI port of the IP wrapper and reports TXN_DONE, a sticky ERROR flag and an error count.

## Interface
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width; 32 or 64.
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h4000_0000: address of index 0.
- C_M_TRANSACTIONS_NUM, 4: transfers per pass; range 1..256.
- C_M_START_DATA_VALUE, 32'hAA00_0000: data of index 0, zero-extended to the data width.
- M_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- INIT_AXI_TXN  in  1  start request; acts on its rising edge.
- MODE  in  2  sampled at start: 00 write+read-compare, 01 write-only, 10 read-compare-only, 11 treated as 00.
- TXN_DONE  out  1  high in DONE until the next accepted start.
- ERROR  out  1  sticky error for the current or last pass.
- ERR_COUNT  out  16  error count for the pass; saturates at 16'hFFFF.
- M_AXI_AW{ADDR,PROT,VALID}/AWREADY, M_AXI_W{DATA,STRB,VALID}/WREADY, M_AXI_B{RESP,VALID}/BREADY, M_AXI_AR{ADDR,PROT,VALID}/ARREADY, M_AXI_R{DATA,RESP,VALID}/RREADY: standard AXI4-Lite master channels at the parameter widths.

## Operation
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- Start detection:
  - INIT_AXI_TXN is registered once.
  - A start is accepted when the input is high, the registered copy is low, and the state is IDLE or DONE.
  - Edges in any other state are ignored.
- On an accepted start:
  - Latch MODE.
  - Clear the index, ERROR, ERR_COUNT and TXN_DONE.
  - Mode 10 goes to RADDR; every other mode goes to WADDR.
- Addressing and data for index i:
  - Address = BASE + i*(C_M_AXI_DATA_WIDTH/8), truncated to the address width.
  - Data = START + i, modulo 2^C_M_AXI_DATA_WIDTH.
  - WSTRB is all ones. AWPROT and ARPROT are 3'b000.
- WADDR:
  - AWVALID and WVALID assert together.
  - Each VALID drops on its own handshake and is never reasserted for the same index.
  - Move to WRESP once both handshakes have completed; they may occur in the same cycle.
- WRESP:
  - BREADY is high.
  - On BVALID: if BRESP[1] is set, it is an error.
  - If i < N-1: increment i and go to WADDR.
  - Otherwise: modes 00/11 reset i to 0 and go to RADDR; mode 01 goes to DONE.
- RADDR: ARVALID is held high until ARREADY, then go to RDATA.
- RDATA:
  - RREADY is high.
  - On RVALID: RDATA != expected is one error; RRESP[1] set is one error. Both together count 2.
  - If i < N-1: increment i and go to RADDR. Otherwise go to DONE.
- Errors never abort a pass; all N transfers always complete.
- ERROR = (ERR_COUNT != 0), registered.
- DONE: TXN_DONE = 1; ERROR and ERR_COUNT hold until the next accepted start.

## Timing
- Reset value of every output is 0: all VALIDs, BREADY, RREADY, addresses, WDATA, TXN_DONE, ERROR, ERR_COUNT.
- Reset is asynchronous: assertion clears all state and outputs immediately, including mid-handshake. There is no resume; the first start after reset begins at index 0.
- All outputs are registered. Channel signals become valid in the cycle after the state is entered.
- Start latency: INIT edge sampled at clock edge k → AWVALID (or ARVALID) high after edge k+1.
- With a zero-wait slave:
  - Each write takes 2 cycles (WADDR, WRESP) and each read takes 2 cycles.
  - TXN_DONE rises the cycle after the final B or R handshake.
  - Mode 00 with N=4 takes 16 cycles from first AWVALID to TXN_DONE.
- VALID signals are never withdrawn before their READY. Address and data are stable while VALID is high.

## Test plan
- Reset: hold ARESETN low 200 ns, then high with no INIT → all outputs remain 0 and no VALID asserts.
- Mode 00, N=4, zero-wait VIP slave memory:
  - Writes go to 0x4000_0000/04/08/0C with data AA000000..AA000003.
  - Reads return the same values.
  - Result: TXN_DONE=1, ERROR=0, ERR_COUNT=0, 16 cycles.
- Backpressure: AWREADY delayed 3 cycles, WREADY immediate, BVALID delayed 2 cycles → WVALID high for exactly 1 cycle, AWVALID held 4 cycles, no duplicate beats, final status clean.
- Injected faults:
  - Slave corrupts read index 2 → ERROR=1, ERR_COUNT=1, all 4 reads still issued.
  - Additionally, BRESP=2'b10 on write 0 → ERR_COUNT=2.
- Mode 01 then mode 10: write-only pass completes with no AR traffic. The following read-only pass compares clean with ERR_COUNT=0.
- Reset and restart:
  - ARESETN low while ARVALID is high → ARVALID drops without a clock edge.
  - A new INIT edge restarts at address 0x4000_0000.
  - An INIT edge while in WRESP is ignored.

Source files
------------

// File: rtl/axi4_lite_master_tgen.sv
// AXI4-Lite master traffic generator: runs a batch of single-beat writes and/or
// read-compares over an incrementing address/data pattern and counts errors.
module axi4_lite_master_tgen #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH         = 32,
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned C_M_TRANSACTIONS_NUM       = 4,
    parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [15:0]                       ERR_COUNT,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW         = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW         = C_M_AXI_DATA_WIDTH;
    localparam int unsigned N          = C_M_TRANSACTIONS_NUM;
    localparam int unsigned IW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BYTE_SHIFT = $clog2(DW / 8);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] MODE_WO = 2'b01;
    localparam logic [1:0] MODE_RO = 2'b10;

    function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] idx);
        return AW'(C_M_TARGET_SLAVE_BASE_ADDR) + (AW'(idx) << BYTE_SHIFT);
    endfunction

    function automatic logic [DW-1:0] f_data(input logic [IW-1:0] idx);
        return DW'(C_M_START_DATA_VALUE) + DW'(idx);
    endfunction

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          r_init_q;
    logic [1:0]    r_mode;
    logic [IW-1:0] r_idx;
    logic          r_start_pend;
    logic          r_aw_done;
    logic          r_w_done;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic [AW-1:0] r_awaddr;
    logic [AW-1:0] r_araddr;
    logic [DW-1:0] r_wdata;
    logic          r_txn_done;
    logic          r_error;
    logic [15:0]   r_err_count;

    logic          w_start;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_aw_ok;
    logic          w_w_ok;
    logic          w_last;
    logic [IW-1:0] w_idx_inc;
    logic [DW-1:0] w_exp_data;
    logic [1:0]    w_err_inc;
    logic [16:0]   w_cnt_sum;
    logic [15:0]   w_cnt_next;
    logic          w_unused_resp;

    assign w_start    = INIT_AXI_TXN && !r_init_q && (r_state == S_IDLE || r_state == S_DONE);
    assign w_aw_hs    = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs     = r_wvalid && M_AXI_WREADY;
    assign w_b_hs     = r_bready && M_AXI_BVALID;
    assign w_ar_hs    = r_arvalid && M_AXI_ARREADY;
    assign w_r_hs     = r_rready && M_AXI_RVALID;
    assign w_aw_ok    = r_aw_done || w_aw_hs;
    assign w_w_ok     = r_w_done || w_w_hs;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_exp_data = f_data(r_idx);

    // Only bit 1 of a response signals SLVERR/DECERR.
    assign w_unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_comb begin
        w_err_inc = 2'd0;
        if (r_state == S_WRESP && w_b_hs && M_AXI_BRESP[1]) begin
            w_err_inc = 2'd1;
        end else if (r_state == S_RDATA && w_r_hs) begin
            w_err_inc = {1'b0, (M_AXI_RDATA != w_exp_data)} + {1'b0, M_AXI_RRESP[1]};
        end
    end

    assign w_cnt_sum  = {1'b0, r_err_count} + 17'(w_err_inc);
    assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = (MODE == MODE_RO) ? S_RADDR : S_WADDR;
                end
            end
            S_WADDR: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (w_b_hs) begin
                    if (!w_last) begin
                        w_state_next = S_WADDR;
                    end else if (r_mode == MODE_WO) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (w_ar_hs) begin
                    w_state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_r_hs) begin
                    w_state_next = w_last ? S_DONE : S_RADDR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state      <= S_IDLE;
            r_init_q     <= 1'b0;
            r_mode       <= 2'b00;
            r_idx        <= '0;
            r_start_pend <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_txn_done   <= 1'b0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_init_q <= INIT_AXI_TXN;
            r_state  <= w_state_next;
            if (w_start) begin
                // VALIDs rise one cycle after the state is entered (r_start_pend).
                r_mode       <= MODE;
                r_idx        <= '0;
                r_err_count  <= '0;
                r_error      <= 1'b0;
                r_txn_done   <= 1'b0;
                r_start_pend <= 1'b1;
                r_awaddr     <= f_addr(IW'(0));
                r_araddr     <= f_addr(IW'(0));
                r_wdata      <= f_data(IW'(0));
            end else begin
                r_err_count <= w_cnt_next;
                r_error     <= (w_cnt_next != 16'd0);
                case (r_state)
                    S_WADDR: begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_ok && w_w_ok) begin
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_bready  <= 1'b1;
                        end
                        if (r_start_pend) begin
                            r_awvalid    <= 1'b1;
                            r_wvalid     <= 1'b1;
                            r_start_pend <= 1'b0;
                        end
                    end
                    S_WRESP: begin
                        if (w_b_hs) begin
                            r_bready <= 1'b0;
                            if (!w_last) begin
                                r_idx     <= w_idx_inc;
                                r_awaddr  <= f_addr(w_idx_inc);
                                r_wdata   <= f_data(w_idx_inc);
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                            end else if (r_mode != MODE_WO) begin
                                r_idx     <= '0;
                                r_araddr  <= f_addr(IW'(0));
                                r_arvalid <= 1'b1;
                            end else begin
                                r_txn_done <= 1'b1;
                            end
                        end
                    end
                    S_RADDR: begin
                        if (r_start_pend) begin
                            r_arvalid    <= 1'b1;
                            r_start_pend <= 1'b0;
                        end
                        if (w_ar_hs) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                        end
                    end
                    S_RDATA: begin
                        if (w_r_hs) begin
                            r_rready <= 1'b0;
                            if (!w_last) begin
                                r_idx     <= w_idx_inc;
                                r_araddr  <= f_addr(w_idx_inc);
                                r_arvalid <= 1'b1;
                            end else begin
                                r_txn_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TXN_DONE      = r_txn_done;
    assign ERROR         = r_error;
    assign ERR_COUNT     = r_err_count;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
